// File: rtl/game_pkg.sv
// Shared types and constants for the game-score path.
// Contents: state_t (FSM states), bcd_digit_t (one BCD digit),
// MAX_SCORE, and default TARGET / BUST_VAL values.
package game_pkg;
   typedef enum logic [1:0] {PLAY, ADD, CHECK, OVER} state_t;
   typedef logic [3:0] bcd_digit_t;

   localparam int MAX_SCORE    = 99;
   localparam int DEF_TARGET   = 21;
   localparam int DEF_BUST_VAL = 7;
endpackage

// File: rtl/score_keeper_if.sv
// Roll handshake bus between the roll/sum generator (master) and
// score_keeper (slave).
//   roll_valid : sum holds a new roll
//   roll_ready : consumer can accept a roll
//   sum        : roll value 0..15
interface score_keeper_if;
   logic       roll_valid;
   logic       roll_ready;
   logic [3:0] sum;

   modport master (output roll_valid, output sum, input roll_ready);
   modport slave  (input roll_valid, input sum, output roll_ready);
endinterface

// File: rtl/bcd_add_sat.sv
// Combinational adder: two-digit BCD score plus a binary value 0..15,
// saturating at 99.
//   ones_i, tens_i : current BCD digits
//   sum_i          : binary addend 0..15
//   ones_o, tens_o : resulting BCD digits
module bcd_add_sat
   import game_pkg::*;
(
   input  bcd_digit_t ones_i,
   input  bcd_digit_t tens_i,
   input  logic [3:0] sum_i,
   output bcd_digit_t ones_o,
   output bcd_digit_t tens_o
);
   logic [4:0] t;       // ones + sum, 0..24
   logic [4:0] tens_w;  // tens after carry, 0..11
   logic [4:0] ones_w;

   always_comb begin
      t      = 5'(ones_i) + 5'(sum_i);
      ones_w = t;
      tens_w = 5'(tens_i);
      if (t >= 5'd20) begin
         ones_w = t - 5'd20;
         tens_w = 5'(tens_i) + 5'd2;
      end else if (t >= 5'd10) begin
         ones_w = t - 5'd10;
         tens_w = 5'(tens_i) + 5'd1;
      end
      // Ones is always 0..9 here, so any tens carry past 9 means > MAX_SCORE.
      if (tens_w > 5'd9) begin
         ones_o = 4'd9;
         tens_o = 4'd9;
      end else begin
         ones_o = ones_w[3:0];
         tens_o = tens_w[3:0];
      end
   end
endmodule

// File: rtl/score_keeper.sv
// Game-score controller: accepts one roll per PLAY visit over roll_if,
// accumulates it into a two-digit BCD score, and ends the game on
// reaching TARGET or (with SCORE_KEEPER_BUST_EN defined) on a roll
// equal to BUST_VAL.
//   clk, rst_n           : clock, synchronous active-low reset
//   roll_if (slave)      : roll_valid / roll_ready / sum handshake
//   restart              : start new game, honoured only in OVER
//   score_ones/tens      : BCD score digits
//   gameover_s           : high while in OVER
// Optional feature macro: SCORE_KEEPER_BUST_EN.
module score_keeper
   import game_pkg::*;
#(
   parameter int TARGET   = DEF_TARGET,
   parameter int BUST_VAL = DEF_BUST_VAL
) (
   input  logic                 clk,
   input  logic                 rst_n,
   score_keeper_if.slave        roll_if,
   input  logic                 restart,
   output bcd_digit_t           score_ones,
   output bcd_digit_t           score_tens,
   output logic                 gameover_s
);
   state_t     state_q, state_d;
   logic [3:0] sum_q, sum_d;
   bcd_digit_t ones_q, ones_d, tens_q, tens_d;
   logic       go_q, go_d;
   bcd_digit_t add_ones, add_tens;
   logic [6:0] score_dec;

   bcd_add_sat u_add (
      .ones_i (ones_q),
      .tens_i (tens_q),
      .sum_i  (sum_q),
      .ones_o (add_ones),
      .tens_o (add_tens)
   );

   assign score_dec = 7'(tens_q) * 7'd10 + 7'(ones_q);

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      ones_d  = ones_q;
      tens_d  = tens_q;
      go_d    = go_q;
      case (state_q)
         PLAY: begin
            // ready is implied by being in PLAY
            if (roll_if.roll_valid) begin
               sum_d   = roll_if.sum;
               state_d = ADD;
            end
         end
         ADD: begin
`ifdef SCORE_KEEPER_BUST_EN
            if (sum_q == 4'(BUST_VAL)) begin
               go_d    = 1'b1;
               state_d = OVER;
            end else begin
               ones_d  = add_ones;
               tens_d  = add_tens;
               state_d = CHECK;
            end
`else
            ones_d  = add_ones;
            tens_d  = add_tens;
            state_d = CHECK;
`endif
         end
         CHECK: begin
            if (score_dec >= 7'(TARGET)) begin
               go_d    = 1'b1;
               state_d = OVER;
            end else begin
               state_d = PLAY;
            end
         end
         OVER: begin
            if (restart) begin
               ones_d  = '0;
               tens_d  = '0;
               go_d    = 1'b0;
               state_d = PLAY;
            end
         end
         default: state_d = PLAY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= PLAY;
         sum_q   <= '0;
         ones_q  <= '0;
         tens_q  <= '0;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         ones_q  <= ones_d;
         tens_q  <= tens_d;
         go_q    <= go_d;
      end
   end

   assign roll_if.roll_ready = (state_q == PLAY);
   assign score_ones         = ones_q;
   assign score_tens         = tens_q;
   assign gameover_s         = go_q;
endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;
   import game_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic restart, s_restart;
   bcd_digit_t ones, tens, s_ones, s_tens;
   logic go, s_go;
   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   score_keeper_if rif ();
   score_keeper_if sif ();

   score_keeper #(.TARGET(21), .BUST_VAL(7)) u_dut (
      .clk(clk), .rst_n(rst_n), .roll_if(rif), .restart(restart),
      .score_ones(ones), .score_tens(tens), .gameover_s(go));

   score_keeper #(.TARGET(99), .BUST_VAL(7)) u_sat (
      .clk(clk), .rst_n(rst_n), .roll_if(sif), .restart(s_restart),
      .score_ones(s_ones), .score_tens(s_tens), .gameover_s(s_go));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; restart = 1'b0; s_restart = 1'b0;
      rif.roll_valid = 1'b0; rif.sum = '0;
      sif.roll_valid = 1'b0; sif.sum = '0;
      step();
      chk("rst_score", {tens, ones}, 8'h00);
      chk("rst_go",    8'(go), 8'h0);
      chk("rst_ready", 8'(rif.roll_ready), 8'h1);
      rst_n = 1'b1;
      step(); step();
      chk("idle_score", {tens, ones}, 8'h00);
      chk("idle_ready", 8'(rif.roll_ready), 8'h1);

      // roll 9
      rif.roll_valid = 1'b1; rif.sum = 4'd9;
      step();                                   // N: accepted
      rif.roll_valid = 1'b0;
      chk("r9_busy", 8'(rif.roll_ready), 8'h0);
      step();                                   // N+1
      chk("r9_score", {tens, ones}, 8'h09);
      step();                                   // N+2
      chk("r9_ready", 8'(rif.roll_ready), 8'h1);
      chk("r9_go",    8'(go), 8'h0);

      // roll 8 -> 17
      rif.roll_valid = 1'b1; rif.sum = 4'd8;
      step(); rif.roll_valid = 1'b0;
      step();
      chk("r8_score", {tens, ones}, 8'h17);
      step();
      chk("r8_ready", 8'(rif.roll_ready), 8'h1);
      chk("r8_go",    8'(go), 8'h0);

      // roll 6 -> 23 reaches target; a held valid with sum 5 must be ignored
      rif.roll_valid = 1'b1; rif.sum = 4'd6;
      step();
      rif.sum = 4'd5;
      step();
      chk("r6_score", {tens, ones}, 8'h23);
      chk("r6_go_n1", 8'(go), 8'h0);
      step();
      chk("r6_go",    8'(go), 8'h1);
      chk("r6_ready", 8'(rif.roll_ready), 8'h0);
      step(); step(); step();
      chk("over_hold_score", {tens, ones}, 8'h23);
      chk("over_hold_go",    8'(go), 8'h1);

      // restart with roll_valid still high (sum 5)
      restart = 1'b1;
      step();                                   // M
      restart = 1'b0;
      chk("rs_score", {tens, ones}, 8'h00);
      chk("rs_go",    8'(go), 8'h0);
      chk("rs_ready", 8'(rif.roll_ready), 8'h1);
      step();                                   // M+1: accepted here
      rif.roll_valid = 1'b0;
      chk("rs_acc_ready", 8'(rif.roll_ready), 8'h0);
      chk("rs_acc_score", {tens, ones}, 8'h00);
      step();
      chk("rs_r5_score", {tens, ones}, 8'h05);
      step();
      chk("rs_r5_ready", 8'(rif.roll_ready), 8'h1);

      // restart ignored outside OVER
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("rs_ignored", {tens, ones}, 8'h05);

      // reset held 3 cycles mid-ADD
      rif.roll_valid = 1'b1; rif.sum = 4'd3;
      step(); rif.roll_valid = 1'b0;            // now in ADD
      rst_n = 1'b0;
      step(); step(); step();
      rst_n = 1'b1;
      chk("midrst_score", {tens, ones}, 8'h00);
      chk("midrst_go",    8'(go), 8'h0);
      chk("midrst_ready", 8'(rif.roll_ready), 8'h1);
      step();
      chk("midrst_after", {tens, ones}, 8'h00);

      // zero roll: score unchanged, flow continues
      rif.roll_valid = 1'b1; rif.sum = 4'd0;
      step(); rif.roll_valid = 1'b0;
      step(); step();
      chk("r0_score", {tens, ones}, 8'h00);
      chk("r0_ready", 8'(rif.roll_ready), 8'h1);

      // bust path: 4 then 7
      rif.roll_valid = 1'b1; rif.sum = 4'd4;
      step(); rif.roll_valid = 1'b0;
      step(); step();
      chk("b4_score", {tens, ones}, 8'h04);
      rif.roll_valid = 1'b1; rif.sum = 4'd7;
      step(); rif.roll_valid = 1'b0;
      step();                                   // N+1
`ifdef SCORE_KEEPER_BUST_EN
      chk("bust_score", {tens, ones}, 8'h04);
      chk("bust_go",    8'(go), 8'h1);
      step();
      chk("bust_ready", 8'(rif.roll_ready), 8'h0);
`else
      chk("nobust_score", {tens, ones}, 8'h11);
      chk("nobust_go",    8'(go), 8'h0);
      step();
      chk("nobust_ready", 8'(rif.roll_ready), 8'h1);
`endif

      // saturation on TARGET=99 instance: 6 x 15 = 90, then +15 -> 99
      for (int i = 0; i < 6; i++) begin
         sif.roll_valid = 1'b1; sif.sum = 4'd15;
         step(); sif.roll_valid = 1'b0;
         step(); step();
      end
      chk("sat_pre_score", {s_tens, s_ones}, 8'h90);
      chk("sat_pre_go",    8'(s_go), 8'h0);
      sif.roll_valid = 1'b1; sif.sum = 4'd15;
      step(); sif.roll_valid = 1'b0;
      step();
      chk("sat_score", {s_tens, s_ones}, 8'h99);
      step();
      chk("sat_go",    8'(s_go), 8'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
